iiitb_bcd2bin: RTL and testbench
================================

Name: iiitb_bcd2bin

Overview:
- Sequential BCD-to-binary converter. It consumes a packed multi-digit BCD word, for example the {Qz,Qu} digit pair produced by the project's BCD counter.
- It returns the equivalent unsigned binary value, computed MSD first by Horner accumulation (acc = acc*10 + digit), one digit per enabled clock.
- Valid/ready handshakes on both input and output. An EN input freezes progress, in the same style as the counter's enable.
- Sits between BCD sources (counter or IO pads) and binary consumers (wishbone/LA readback) inside user_proj_example.

Parameters:
- DIGITS, 2, number of BCD digits in bcd_in (1..8).
- BIN_W, 7, width of bin_out; must be >= ceil(log2(10^DIGITS)) for exact results.

Ports:
- CK  input  1  clock, rising-edge.
- RN  input  1  asynchronous active-low reset.
- EN  input  1  conversion enable; 0 holds the FSM and all registers (handshake outputs still reflect current state).
- in_valid  input  1  bcd_in holds a word to convert.
- in_ready  output  1  block can accept a word.
- bcd_in  input  4*DIGITS  packed BCD, MSD in bits [4*DIGITS-1:4*DIGITS-4].
- bin_out  output  BIN_W  converted binary result.
- out_valid  output  1  bin_out (and err) valid.
- out_ready  input  1  consumer accepts result.
- busy  output  1  high while in CONV.
- err  output  1  invalid-digit flag; meaningful only with BCD_DIGIT_CHK_EN, constant 0 otherwise.

Behaviour:
- Reset (RN=0, async, any state, including mid-conversion): state=IDLE, in_ready=1, out_valid=0, busy=0, bin_out=0, err=0, acc=0, shift register=0, digit count=0. Any conversion in flight is discarded.
- FSM states IDLE, CONV, DONE. Registered outputs: in_ready=(IDLE), busy=(CONV), out_valid=(DONE).
- IDLE, on a rising edge with EN=1 and in_valid=1 (accept):
  - shift register <= bcd_in, acc <= 0, count <= 0, state -> CONV.
  - With EN=0, in_valid is ignored and the state holds.
- CONV, each rising edge with EN=1:
  - acc <= acc*10 + top nibble (arithmetic modulo 2^BIN_W); shift register <<= 4; count++.
  - On the edge processing digit DIGITS-1: bin_out <= final acc, state -> DONE.
  - With EN=0: no register changes.
- DONE: bin_out and err are held stable while out_valid=1. On a rising edge with out_ready=1 (EN is don't-care), state -> IDLE.
- Latency: out_valid rises exactly DIGITS enabled edges after the accepting edge. Throughput is one word per DIGITS+2 cycles with EN=1 and out_ready=1.
- in_valid asserted outside IDLE is ignored. The source must hold in_valid/bcd_in until in_ready=1. bcd_in is sampled only on the accepting edge; later changes have no effect.
- out_ready asserted outside DONE has no effect.
- Non-BCD nibbles (A-F) without the optional feature are used as raw values, e.g. 8'hFF -> 15*10+15 = 165, truncated to BIN_W bits (165 mod 128 = 37 for BIN_W=7).
- A BIN_W that is too small wraps silently; it is not flagged.

Optional Feature:
- Macro BCD_DIGIT_CHK_EN.
- Defined:
  - Each digit is checked as it is processed in CONV; any nibble > 9 sets a sticky internal flag.
  - On entry to DONE, err <= flag and bin_out <= 0 if the flag is set (normal result otherwise).
  - The flag clears on accept and on reset.
- Not defined: err is tied to 0, there is no check logic, and invalid digits are converted as raw values per Behaviour.

Test Plan:
- Reset check: assert RN=0 mid-CONV -> immediately in_ready=1, busy=0, out_valid=0, bin_out=0. After release, next input 8'h42 -> bin_out=42.
- Basic, DIGITS=2, EN=1: bcd_in=8'h99 accepted at edge k -> busy=1 on edges k+1..k+2. Then out_valid=1 and bin_out=99 after edge k+2. Also 8'h00 -> 0 and 8'h10 -> 10.
- Backpressure and stall:
  - Hold out_ready=0 for 5 cycles after 8'h57 -> out_valid and bin_out=57 stable, in_ready=0, and a new in_valid with 8'h12 is ignored.
  - Pulse EN=0 for 3 cycles during CONV -> out_valid delayed by exactly 3 cycles, bin_out=57.
- Back-to-back: stream the counter sequence 8'h00..8'h99 with out_ready=1 -> bin_out sequence 0..99 with no drops or duplicates.
- Invalid digit:
  - bcd_in=8'h1A, macro undefined -> bin_out=20, err=0.
  - Same input with BCD_DIGIT_CHK_EN defined -> bin_out=0, err=1; next input 8'h25 -> err=0, bin_out=25.
- Parameter sweep: DIGITS=4, BIN_W=14, bcd_in=16'h9999 -> bin_out=9999 four enabled edges after accept.

Source files
------------

// File: rtl/iiitb_bcd2bin.sv
// Sequential BCD-to-binary converter: Horner accumulation, one digit per enabled clock, MSD first.
// Optional macro BCD_DIGIT_CHK_EN flags non-BCD nibbles via err and zeroes the result.
module iiitb_bcd2bin #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  EN,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state_q;
    logic [4*DIGITS-1:0]   shift_q;
    logic [BIN_W-1:0]      acc_q, acc_d;
    logic [BIN_W-1:0]      bin_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  in_ready_q, busy_q, out_valid_q;
    logic [3:0]            nib;
    logic                  last;

    // All arithmetic stays BIN_W wide so oversize values wrap modulo 2^BIN_W.
    always_comb begin
        nib   = shift_q[4*DIGITS-1 -: 4];
        acc_d = (acc_q * BIN_W'(10)) + BIN_W'(nib);
        last  = (cnt_q == CNT_W'(DIGITS-1));
    end

`ifdef BCD_DIGIT_CHK_EN
    logic flag_q, flag_d, err_q;
    always_comb flag_d = flag_q | (nib > 4'd9);
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef BCD_DIGIT_CHK_EN
            flag_q      <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (EN && in_valid) begin
                    shift_q    <= bcd_in;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= CONV;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
`ifdef BCD_DIGIT_CHK_EN
                    flag_q     <= 1'b0;
`endif
                end
                CONV: if (EN) begin
                    acc_q   <= acc_d;
                    shift_q <= shift_q << 4;
                    cnt_q   <= cnt_q + CNT_W'(1);
`ifdef BCD_DIGIT_CHK_EN
                    flag_q  <= flag_d;
`endif
                    if (last) begin
`ifdef BCD_DIGIT_CHK_EN
                        bin_q <= flag_d ? '0 : acc_d;
                        err_q <= flag_d;
`else
                        bin_q <= acc_d;
`endif
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                // Leaving DONE ignores EN so a stalled pipe can still drain.
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;

endmodule

// File: tb/tb_iiitb_bcd2bin.sv
// Bench for iiitb_bcd2bin: cycle model with per-cycle compare plus directed literal checks.
module tb_iiitb_bcd2bin;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 7;

    logic CK = 1'b0;
    logic RN = 1'b0;
    logic EN = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic in_ready, out_valid, busy, err;
    logic [BIN_W-1:0] bin_out;

    logic EN4 = 1'b1;
    logic in_valid4 = 1'b0;
    logic out_ready4 = 1'b1;
    logic [15:0] bcd4 = '0;
    logic in_ready4, out_valid4, busy4, err4;
    logic [13:0] bin4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_out = 0;

    always #5 CK = ~CK;
    always @(posedge CK) cyc++;

    iiitb_bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .CK(CK), .RN(RN), .EN(EN), .in_valid(in_valid), .in_ready(in_ready),
        .bcd_in(bcd_in), .bin_out(bin_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .err(err)
    );

    iiitb_bcd2bin #(.DIGITS(4), .BIN_W(14)) dut4 (
        .CK(CK), .RN(RN), .EN(EN4), .in_valid(in_valid4), .in_ready(in_ready4),
        .bcd_in(bcd4), .bin_out(bin4), .out_valid(out_valid4),
        .out_ready(out_ready4), .busy(busy4), .err(err4)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference value: positional sum of digits times powers of ten, reduced mod 2^BIN_W.
    function automatic longint ref_val(input logic [4*DIGITS-1:0] w);
        longint v = 0;
        longint p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v += longint'(w[4*i +: 4]) * p;
            p *= 10;
        end
        return v % (longint'(1) << BIN_W);
    endfunction

    function automatic bit has_bad(input logic [4*DIGITS-1:0] w);
        for (int i = 0; i < DIGITS; i++)
            if (w[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    bit     m_busy = 0, m_done = 0, m_err = 0;
    int     m_left = 0;
    longint m_val = 0;

    // Model: accept -> DIGITS enabled edges of work -> result held until taken.
    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            m_busy = 0; m_done = 0; m_left = 0; m_val = 0; m_err = 0;
        end else if (m_done) begin
            if (out_ready) begin m_done = 0; n_out++; end
        end else if (m_busy) begin
            if (EN) begin
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_done = 1; end
            end
        end else if (EN && in_valid) begin
            m_busy = 1;
            m_left = DIGITS;
            m_val  = ref_val(bcd_in);
            m_err  = 0;
`ifdef BCD_DIGIT_CHK_EN
            if (has_bad(bcd_in)) begin m_val = 0; m_err = 1; end
`endif
        end
    end

    always @(negedge CK) begin
        if (RN) begin
            chk("model in_ready", in_ready, !m_busy && !m_done);
            chk("model busy", busy, m_busy);
            chk("model out_valid", out_valid, m_done);
            if (m_done) begin
                chk("model bin_out", bin_out, m_val);
                chk("model err", err, m_err);
            end
        end
    end

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic convert(input logic [7:0] w, input int exp, input bit exp_err,
                           input int stall, input string name);
        int n = 0;
        int lat = 0;
        while (!in_ready && n < 50) begin tick; n++; end
        if (!in_ready) chk({name, " in_ready timeout"}, 0, 1);
        in_valid = 1'b1;
        bcd_in   = w;
        tick;
        in_valid = 1'b0;
        if (stall > 0) begin
            tick; lat++;
            EN = 1'b0;
            repeat (stall) begin tick; lat++; end
            EN = 1'b1;
        end
        while (!out_valid && lat < 50) begin tick; lat++; end
        chk({name, " latency"}, lat, DIGITS + stall);
        chk({name, " bin_out"}, bin_out, exp);
        chk({name, " err"}, err, exp_err);
        if (out_ready) tick;
    endtask

    initial begin
        int n, t0, tl, n0;

        repeat (2) tick;
        chk("reset in_ready", in_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset bin_out", bin_out, 0);
        chk("reset err", err, 0);
        RN = 1'b1;
        tick;

        in_valid = 1'b1; bcd_in = 8'h99;
        tick;
        in_valid = 1'b0;
        chk("99 busy k+1", busy, 1);
        tick;
        chk("99 busy k+2", busy, 1);
        chk("99 out_valid early", out_valid, 0);
        tick;
        chk("99 out_valid", out_valid, 1);
        chk("99 bin_out", bin_out, 99);
        tick;

        convert(8'h00, 0, 0, 0, "00");
        convert(8'h10, 10, 0, 0, "10");

        // Async reset in the middle of a conversion.
        in_valid = 1'b1; bcd_in = 8'h55;
        tick;
        in_valid = 1'b0;
        tick;
        RN = 1'b0;
        #1;
        chk("midreset in_ready", in_ready, 1);
        chk("midreset busy", busy, 0);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset bin_out", bin_out, 0);
        tick;
        RN = 1'b1;
        tick;
        convert(8'h42, 42, 0, 0, "42");

        out_ready = 1'b0;
        convert(8'h57, 57, 0, 0, "57 bp");
        in_valid = 1'b1; bcd_in = 8'h12;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp out_valid", out_valid, 1);
            chk("bp bin_out", bin_out, 57);
            chk("bp in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("bp drained", in_ready, 1);

        convert(8'h57, 57, 0, 3, "57 stall");

`ifdef BCD_DIGIT_CHK_EN
        convert(8'h1A, 0, 1, 0, "1A chk");
        convert(8'h25, 25, 0, 0, "25 after bad");
`else
        convert(8'h1A, 20, 0, 0, "1A raw");
        convert(8'hFF, 37, 0, 0, "FF raw");
`endif

        // Back-to-back stream of the counter sequence.
        n0 = n_out; t0 = 0; tl = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            bcd_in = {4'(i / 10), 4'(i % 10)};
            n = 0;
            while (!in_ready && n < 20) begin tick; n++; end
            if (!in_ready) chk("stream in_ready timeout", 0, 1);
            if (i == 0) t0 = cyc;
            tl = cyc;
            tick;
        end
        in_valid = 1'b0;
        n = 0;
        while (n_out - n0 < 100 && n < 50) begin tick; n++; end
        chk("stream count", n_out - n0, 100);
        chk("stream period", tl - t0, 99 * (DIGITS + 2));

        in_valid4 = 1'b1; bcd4 = 16'h9999;
        tick;
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 50) begin tick; n++; end
        chk("d4 latency", n, 4);
        chk("d4 bin_out", bin4, 9999);
        chk("d4 err", err4, 0);
        tick;
        chk("d4 back to idle", in_ready4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
